// File: rtl/fetch_pc_unit_if.sv
// Bus bundle between the fetch unit and its neighbours: the PC incrementer,
// instruction memory, decode and the execute-stage redirect.
interface fetch_pc_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_addr;

    // Fetch unit side.
    modport master (
        output pc,
        input  pc_inc,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect_valid,
        input  redirect_addr
    );

    // Environment side (adder, memory, decode, execute).
    modport slave (
        input  pc,
        output pc_inc,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect_valid,
        output redirect_addr
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | one-cycle gap; launches a request at the (possibly redirected) PC
//   REQ   | request outstanding, address held until imem_ack
//   HOLD  | fetched instruction presented to decode until accepted/squashed
//
// A redirect that arrives while a request is in flight cannot cancel the
// memory access, so it sets kill and the returning data is thrown away.
// All outputs come straight from registers.
module fetch_pc_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic             kill_q, kill_d;

    assign bus.pc          = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;

    // State and datapath registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            addr_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state and next-register values; redirect always wins over increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        kill_d  = kill_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                req_d   = 1'b1;
                state_d = REQ;
                if (bus.redirect_valid) begin
                    pc_d   = bus.redirect_addr;
                    addr_d = bus.redirect_addr;
                end else begin
                    addr_d = pc_q;
                end
            end

            REQ: begin
                if (bus.imem_ack) begin
                    req_d = 1'b0;
                    if (kill_q || bus.redirect_valid) begin
                        // Stale data: drop it and restart from the target.
                        kill_d  = 1'b0;
                        state_d = IDLE;
                        if (bus.redirect_valid) begin
                            pc_d = bus.redirect_addr;
                        end
                    end else begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = addr_q;
                        pc_d    = bus.pc_inc;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d   = bus.redirect_addr;
                    kill_d = 1'b1;
                end
            end

            HOLD: begin
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_addr;
                    addr_d  = bus.redirect_addr;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
